// File: rtl/sixrom_romsel_if.sv
// Edge-connector bus and DIP switch bundle for the six-slot ROM board CPLD.
// The master side is the CPC/board environment; the slave side is the CPLD.
interface sixrom_romsel_if;
    logic       A15;
    logic       A14;
    logic       A13;
    logic [7:0] D;
    logic       IOREQ_B;
    logic       WR_B;
    logic       RD_B;
    logic       ROMEN_B;
    logic       BUSACK_B;
    logic [7:0] dip;
    logic       rom01cs_b;
    logic       rom23cs_b;
    logic       rom45cs_b;
    logic       roma14;
    logic       romoe_b;
    logic       romdis_pre;

    modport master (
        output A15, A14, A13, D, IOREQ_B, WR_B, RD_B, ROMEN_B, BUSACK_B, dip,
        input  rom01cs_b, rom23cs_b, rom45cs_b, roma14, romoe_b, romdis_pre
    );

    modport slave (
        input  A15, A14, A13, D, IOREQ_B, WR_B, RD_B, ROMEN_B, BUSACK_B, dip,
        output rom01cs_b, rom23cs_b, rom45cs_b, roma14, romoe_b, romdis_pre
    );
endinterface

// File: rtl/sixrom_romsel.sv
// Upper-ROM select capture and EEPROM chip-select generation.
// A write to &DFxx (A13 = 0) latches the ROM number; if it falls in this
// board's group and an enabled slot, the matching 28C256 is served.
module sixrom_romsel (
    input logic            CLK,
    input logic            RESET,
    sixrom_romsel_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StArm, StWaitRel} state_e;

    state_e     state_q, state_d;
    logic       valid_q, valid_d;
    logic [2:0] slot_q, slot_d;

    logic strobe;
    logic wr_sel;
    logic slot_en;
    logic hit;
    logic acc;

    // Select-port decode and ROM-number hit test against the live DIP setting.
    always_comb begin
        strobe = !bus.IOREQ_B && !bus.WR_B;
        wr_sel = strobe && !bus.A13 && bus.BUSACK_B;
        unique case (bus.D[2:1])
            2'd0:    slot_en = bus.dip[0];
            2'd1:    slot_en = bus.dip[1];
            2'd2:    slot_en = bus.dip[2];
            default: slot_en = 1'b0;
        endcase
        hit = bus.dip[7] && (bus.D[7:3] == {1'b0, bus.dip[6:3]})
              && (bus.D[2:0] <= 3'd5) && slot_en;
    end

    // Capture FSM: two consecutive qualified edges arm and capture, then wait
    // for the strobe to release so a long strobe captures only once.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        slot_d  = slot_q;
        if (!bus.BUSACK_B) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (wr_sel) state_d = StArm;
                end
                StArm: begin
                    if (wr_sel) begin
                        state_d = StWaitRel;
                        valid_d = hit;
                        if (hit) slot_d = bus.D[2:0];
                    end else begin
                        state_d = StIdle;
                    end
                end
                StWaitRel: begin
                    if (!strobe) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and captured selection registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            slot_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            slot_q  <= slot_d;
        end
    end

    // Combinational ROM access decode; live bus inputs reach the EEPROM pins
    // without a register so access timing follows the gate array directly.
    always_comb begin
        acc            = valid_q && !bus.ROMEN_B && bus.A15 && bus.A14 && bus.BUSACK_B;
        bus.rom01cs_b  = !(acc && (slot_q[2:1] == 2'd0));
        bus.rom23cs_b  = !(acc && (slot_q[2:1] == 2'd1));
        bus.rom45cs_b  = !(acc && (slot_q[2:1] == 2'd2));
        bus.roma14     = valid_q && slot_q[0];
        bus.romoe_b    = !(acc && !bus.RD_B);
        bus.romdis_pre = acc;
    end

endmodule

// File: tb/tb_sixrom_romsel.sv
// Self-checking bench for sixrom_romsel: a behavioural model of the ROM
// selection, compared every cycle, plus hand-computed literal expectations.
module tb_sixrom_romsel;

    logic CLK;
    logic RESET;

    sixrom_romsel_if bus ();

    sixrom_romsel dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // Model state: selected ROM slot, whether it belongs to this board, how
    // many consecutive edges the current select write has been seen, and
    // whether that write has already been taken.
    logic       m_valid;
    logic [2:0] m_slot;
    int         m_run;
    logic       m_taken;

    task automatic chk(input string name, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b (cs01 cs23 cs45 a14 oe romdis)", name, got, exp);
        end
    endtask

    function automatic logic [5:0] dut_out();
        return {bus.rom01cs_b, bus.rom23cs_b, bus.rom45cs_b,
                bus.roma14, bus.romoe_b, bus.romdis_pre};
    endfunction

    function automatic logic [5:0] model_out();
        logic acc;
        int   dev;
        acc = m_valid && !bus.ROMEN_B && bus.A15 && bus.A14 && bus.BUSACK_B;
        dev = int'(m_slot) / 2;
        return {!(acc && dev == 0), !(acc && dev == 1), !(acc && dev == 2),
                m_valid && (int'(m_slot) % 2 == 1), !(acc && !bus.RD_B), acc};
    endfunction

    // Behavioural model of the select-port capture.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_valid <= 1'b0;
            m_slot  <= 3'd0;
            m_run   <= 0;
            m_taken <= 1'b0;
        end else begin
            automatic logic writing = !bus.IOREQ_B && !bus.WR_B;
            automatic int   rom     = int'(bus.D);
            automatic int   sl      = rom % 8;
            automatic logic ok;
            if (!bus.BUSACK_B) begin
                m_run   <= 0;
                m_taken <= 1'b0;
            end else if (m_taken) begin
                if (!writing) m_taken <= 1'b0;
            end else if (writing && !bus.A13) begin
                if (m_run + 1 >= 2) begin
                    ok = bus.dip[7] && (rom / 8 == int'(bus.dip[6:3])) && sl < 6
                         && bus.dip[sl / 2];
                    m_valid <= ok;
                    if (ok) m_slot <= 3'(sl);
                    m_run   <= 0;
                    m_taken <= 1'b1;
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                m_run <= 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        chk("model", dut_out(), model_out());
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic write_sel(input logic [7:0] data, input int edges);
        bus.D = data; bus.A13 = 1'b0; bus.IOREQ_B = 1'b0; bus.WR_B = 1'b0;
        tick(edges);
        bus.IOREQ_B = 1'b1; bus.WR_B = 1'b1; bus.A13 = 1'b1;
        tick(1);
    endtask

    task automatic rom_read(input string name, input logic rd_b, input logic [5:0] exp);
        bus.ROMEN_B = 1'b0; bus.A15 = 1'b1; bus.A14 = 1'b1; bus.RD_B = rd_b;
        #1;
        chk(name, dut_out(), exp);
        bus.ROMEN_B = 1'b1; bus.RD_B = 1'b1;
        tick(1);
    endtask

    initial begin
        RESET = 1'b1;
        bus.A15 = 1'b0; bus.A14 = 1'b0; bus.A13 = 1'b1; bus.D = 8'h00;
        bus.IOREQ_B = 1'b1; bus.WR_B = 1'b1; bus.RD_B = 1'b1;
        bus.ROMEN_B = 1'b1; bus.BUSACK_B = 1'b1; bus.dip = 8'b1_0000_111;
        tick(2);
        chk("reset_idle", dut_out(), 6'b111_0_1_0);
        RESET = 1'b0;
        tick(1);
        rom_read("reset_read", 1'b0, 6'b111_0_1_0);

        // Group 1, slot 5 with a 3-edge strobe; D changes on the third edge
        // so a second capture would be visible.
        bus.dip = 8'b1_0001_111;
        bus.D = 8'h0D; bus.A13 = 1'b0; bus.IOREQ_B = 1'b0; bus.WR_B = 1'b0;
        tick(1);
        chk("edge1_no_cap", dut_out(), 6'b111_0_1_0);
        tick(1);
        chk("edge2_cap", dut_out(), 6'b111_1_1_0);
        bus.D = 8'h08;
        tick(1);
        chk("edge3_once", dut_out(), 6'b111_1_1_0);
        bus.IOREQ_B = 1'b1; bus.WR_B = 1'b1; bus.A13 = 1'b1;
        tick(1);
        rom_read("read_slot5", 1'b0, 6'b110_1_0_1);

        write_sel(8'h0E, 2);
        rom_read("read_slot6_miss", 1'b0, 6'b111_0_1_0);
        write_sel(8'h0D, 2);
        write_sel(8'h00, 2);
        rom_read("read_group_miss", 1'b0, 6'b111_0_1_0);

        bus.dip = 8'b1_0000_101;
        write_sel(8'h02, 2);
        rom_read("read_rom23_off", 1'b0, 6'b111_0_1_0);
        write_sel(8'h01, 2);
        rom_read("read_slot1", 1'b0, 6'b011_1_0_1);
        rom_read("access_no_rd", 1'b1, 6'b011_1_1_1);

        write_sel(8'h03, 1);
        rom_read("glitch_kept", 1'b0, 6'b011_1_0_1);

        bus.BUSACK_B = 1'b0;
        rom_read("busack_block", 1'b0, 6'b111_1_1_0);
        bus.BUSACK_B = 1'b1;
        tick(1);
        rom_read("busack_after", 1'b0, 6'b011_1_0_1);

        // Reset while waiting for strobe release, strobe held across release.
        bus.D = 8'h05; bus.A13 = 1'b0; bus.IOREQ_B = 1'b0; bus.WR_B = 1'b0;
        tick(2);
        chk("pre_rst_cap", dut_out(), 6'b111_1_1_0);
        tick(1);
        RESET = 1'b1;
        #1;
        chk("rst_mid_strobe", dut_out(), 6'b111_0_1_0);
        tick(1);
        RESET = 1'b0;
        tick(1);
        chk("post_rst_edge1", dut_out(), 6'b111_0_1_0);
        tick(1);
        chk("post_rst_edge2", dut_out(), 6'b111_1_1_0);
        bus.IOREQ_B = 1'b1; bus.WR_B = 1'b1; bus.A13 = 1'b1;
        tick(1);
        rom_read("read_after_rst", 1'b0, 6'b110_1_0_1);

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sixrom_romsel.md
# sixrom_romsel

Upper-ROM select and chip-select generator for the six-slot ROM board's XC9572XL CPLD. It captures Z80 writes to the CPC upper-ROM select port (&DFxx, decoded on A13 = 0) and decides whether the selected ROM number belongs to one of the board's six 16K slots. It then drives the three 28C256 chip selects, the shared A14, the shared output enable and the ROMDIS request on the CPC expansion bus. It sits between the edge-connector bus signals and the EEPROMs.

## Interface
- No parameters; all configuration comes from the DIP switches at capture time.
- CLK  input  1  CPC 4 MHz bus clock; all state on rising edge
- RESET  input  1  asynchronous, active-high reset
- A15, A14, A13  input  1 each  CPU address bits
- D  input  8  CPU data bus (D7..D0), sampled only
- IOREQ_B, WR_B, RD_B  input  1 each  Z80 strobes, active-low
- ROMEN_B  input  1  gate-array ROM enable, active-low
- BUSACK_B  input  1  bus acknowledge, active-low
- dip  input  8  DIP switches, 1 = ON. dip[7] is board enable. dip[6:3] is the ROM group. dip[2], dip[1] and dip[0] enable ROM45, ROM23 and ROM01 respectively.
- rom01cs_b, rom23cs_b, rom45cs_b  output  1 each  EEPROM chip selects, active-low
- roma14  output  1  EEPROM A14; selects the odd slot within a device
- romoe_b  output  1  shared EEPROM output enable, active-low
- romdis_pre  output  1  ROMDIS request to the bus (goes through an external diode), active-high

## Operation
- wr_sel = !IOREQ_B & !WR_B & !A13 & BUSACK_B. The inputs are synchronous to CLK and are used without a synchroniser.
- The capture FSM has three states: IDLE, ARM and WAIT_REL.
  - IDLE: if wr_sel, go to ARM.
  - ARM: if wr_sel, capture and go to WAIT_REL; otherwise go to IDLE (glitch rejected, no capture).
  - WAIT_REL: stay while !IOREQ_B & !WR_B. Return to IDLE when either strobe is high.
  - Exactly one capture occurs per strobe, regardless of strobe length.
- Capture (one edge) decodes D together with the current dip value:
  - hit = dip[7] & (D[7:3] == {0, dip[6:3]}) & (D[2:0] <= 5) & dip[D[2:1]].
  - Registers: valid <= hit; slot <= D[2:0] if hit, otherwise slot is held.
  - A non-hit write always clears valid, because another ROM has been selected.
- DIP changes take effect only at the next capture.
- Combinational outputs, computed from registered valid/slot and live bus inputs:
  - acc = valid & !ROMEN_B & A15 & A14 & BUSACK_B.
  - romXYcs_b = !(acc & slot[2:1] == XY-index), where 0 is ROM01, 1 is ROM23 and 2 is ROM45.
  - roma14 = slot[0] whenever valid, and 0 otherwise.
  - romoe_b = !(acc & !RD_B).
  - romdis_pre = acc.
- When BUSACK_B is low:
  - All chip selects and romoe_b are high and romdis_pre is 0.
  - The FSM is forced to IDLE.
  - valid and slot are held.

## Timing
- Reset values:
  - FSM is IDLE; valid = 0; slot = 0.
  - rom01cs_b = rom23cs_b = rom45cs_b = 1; romoe_b = 1; roma14 = 0; romdis_pre = 0.
- Capture latency: valid and slot update on the 2nd consecutive CLK edge that samples wr_sel true. Outputs reflect the new value immediately after that edge. A strobe must be low for at least 2 CLK edges to capture.
- The ROMEN_B/RD_B/A15/A14 to cs/oe/romdis path is purely combinational, with no register.
- Simultaneous ROM access and capture: outputs use the old valid/slot until the capture edge.
- RESET asserted mid-strobe clears everything at once. If the strobe is still low after release, the FSM restarts from IDLE and needs 2 more sampled edges to capture.
- Back-to-back select writes separated by at least one CLK edge with a strobe high each produce a separate capture.

## Test plan
- Reset, then ROM read (ROMEN_B = 0, A15:A14 = 11, RD_B = 0) with dip = 8'b1_0000_111 -> all cs_b = 1, romoe_b = 1, romdis_pre = 0.
- dip = 8'b1_0001_111; write D = 8'h0D (group 1, slot 5) to &DFxx with the strobe held for 3 edges -> valid = 1 after the 2nd edge. A ROM read then gives rom45cs_b = 0, roma14 = 1, romoe_b = 0, romdis_pre = 1. Only one capture occurs.
- Same dip; write 8'h0E (slot 6), then 8'h00 (wrong group) -> valid = 0 after each; ROM reads give all cs_b = 1 and romdis_pre = 0.
- dip = 8'b1_0000_101 (ROM23 disabled); write 8'h02 -> valid = 0. Write 8'h01 -> rom01cs_b = 0 and roma14 = 1 on read.
- 1-edge strobe glitch carrying D = 8'h03 -> no capture; the previous slot is retained.
- With valid set, drive BUSACK_B = 0 during a ROM read -> cs_b/romoe_b = 1 and romdis_pre = 0. After release, the same slot is served again.
- Assert RESET while in WAIT_REL -> all outputs return to their reset values; a re-held strobe captures 2 edges after release.
